// File: rtl/axi_rt_cfg_sequencer.sv
// Safe reprogramming sequencer for the per-region budget/period registers
// that feed one real-time unit's bandwidth counters.
//
// Software stages new values into shadow registers. A commit isolates the
// RT unit, waits for it to drain, copies every dirty shadow entry to the
// active registers in a single cycle alongside a period-abort pulse, and
// then releases isolation.
//
// Optional feature, enabled by defining AXI_RT_CFG_DRAIN_TIMEOUT_EN:
// DRAIN gives up after DrainTimeout cycles. The sequencer then releases
// isolation without applying anything, keeps the staged values pending,
// and sets a sticky timeout_err_o flag.
module axi_rt_cfg_sequencer #(
    parameter  int NumAddrRegions = 4,
    parameter  int BudgetWidth    = 32,
    parameter  int PeriodWidth    = 32,
    parameter  int DrainTimeout   = 1024,
    localparam int RegionWidth    = (NumAddrRegions > 1) ? $clog2(NumAddrRegions) : 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    // staging port
    input  logic                                      stage_valid_i,
    output logic                                      stage_ready_o,
    input  logic                                      stage_dir_i,
    input  logic [RegionWidth-1:0]                    stage_region_i,
    input  logic [BudgetWidth-1:0]                    stage_budget_i,
    input  logic [PeriodWidth-1:0]                    stage_period_i,
    // commit control and status
    input  logic                                      commit_i,
    output logic                                      pending_o,
    output logic                                      busy_o,
    output logic                                      commit_done_o,
    output logic                                      range_err_o,
    // RT unit handshake
    output logic                                      isolate_o,
`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
    output logic                                      timeout_err_o,
`endif
    input  logic                                      isolated_i,
    output logic                                      imtu_abort_o,
    // active values
    output logic [NumAddrRegions-1:0][BudgetWidth-1:0] w_budget_o,
    output logic [NumAddrRegions-1:0][PeriodWidth-1:0] w_period_o,
    output logic [NumAddrRegions-1:0][BudgetWidth-1:0] r_budget_o,
    output logic [NumAddrRegions-1:0][PeriodWidth-1:0] r_period_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_RELEASE
    } state_e;

    // One bit wider than the region field so that the limit itself is
    // representable even when NumAddrRegions is a power of two.
    localparam logic [RegionWidth:0] RegionLimit = NumAddrRegions[RegionWidth:0];

    state_e state_q, state_d;

    // Index 0 holds the read-direction entries, index 1 the write-direction ones.
    logic [1:0][NumAddrRegions-1:0][BudgetWidth-1:0] shadow_budget_q;
    logic [1:0][NumAddrRegions-1:0][PeriodWidth-1:0] shadow_period_q;
    logic [1:0][NumAddrRegions-1:0][BudgetWidth-1:0] active_budget_q;
    logic [1:0][NumAddrRegions-1:0][PeriodWidth-1:0] active_period_q;
    logic [1:0][NumAddrRegions-1:0]                  dirty_q;
    logic                                            range_err_q;

    logic handshake;
    logic region_ok;
    logic stage_wr;
    logic apply;

    assign handshake = stage_valid_i & stage_ready_o;
    assign region_ok = ({1'b0, stage_region_i} < RegionLimit);
    assign stage_wr  = handshake & region_ok;

`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
    localparam int CntWidth = $clog2(DrainTimeout + 1);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(DrainTimeout - 1);

    logic [CntWidth-1:0] drain_cnt_q;
    logic                timeout_hit;
    logic                timeout_err_q;
    logic                applied_q;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state is always updated with non-blocking
        // assignments so that every register samples pre-edge values.
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs of the commit sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        stage_ready_o = 1'b0;
        isolate_o     = 1'b0;
        imtu_abort_o  = 1'b0;
        commit_done_o = 1'b0;
        apply         = 1'b0;
`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
        timeout_hit   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                stage_ready_o = 1'b1;
                // A write staged in the same cycle as the commit is included.
                if (commit_i && (pending_o || stage_wr)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                isolate_o = 1'b1;
                if (isolated_i) begin
                    state_d = ST_APPLY;
`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
                end else if (drain_cnt_q == CntLast) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_RELEASE;
`endif
                end
            end
            ST_APPLY: begin
                isolate_o    = 1'b1;
                imtu_abort_o = 1'b1;
                apply        = 1'b1;
                state_d      = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!isolated_i) begin
                    state_d = ST_IDLE;
`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
                    commit_done_o = applied_q;
`else
                    commit_done_o = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow staging, dirty tracking and the atomic shadow-to-active copy.
    always_ff @(posedge clk_i) begin
        // NOTE: the shadow and active arrays are reset on purpose: the RT
        // counters must see zero budgets after reset, and a reset mid-commit
        // must discard whatever was staged.
        if (rst_i) begin
            shadow_budget_q <= '0;
            shadow_period_q <= '0;
            active_budget_q <= '0;
            active_period_q <= '0;
            dirty_q         <= '0;
        end else begin
            if (stage_wr) begin
                for (int i = 0; i < NumAddrRegions; i++) begin
                    if (stage_region_i == RegionWidth'(i)) begin
                        shadow_budget_q[stage_dir_i][i] <= stage_budget_i;
                        shadow_period_q[stage_dir_i][i] <= stage_period_i;
                        dirty_q[stage_dir_i][i]         <= 1'b1;
                    end
                end
            end
            // Staging is blocked outside IDLE, so apply never races a write.
            if (apply) begin
                for (int d = 0; d < 2; d++) begin
                    for (int i = 0; i < NumAddrRegions; i++) begin
                        if (dirty_q[d][i]) begin
                            active_budget_q[d][i] <= shadow_budget_q[d][i];
                            active_period_q[d][i] <= shadow_period_q[d][i];
                        end
                    end
                end
                dirty_q <= '0;
            end
        end
    end

    // One-cycle pulse for an accepted write aimed at a nonexistent region.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= handshake & ~region_ok;
        end
    end

`ifdef AXI_RT_CFG_DRAIN_TIMEOUT_EN
    // Drain watchdog: counts DRAIN cycles from zero, remembers whether this
    // commit applied anything, and latches a sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            applied_q     <= 1'b0;
        end else begin
            if (state_q == ST_DRAIN) begin
                drain_cnt_q <= drain_cnt_q + CntWidth'(1);
            end else begin
                drain_cnt_q <= '0;
            end
            if (timeout_hit) begin
                timeout_err_q <= 1'b1;
            end
            if (apply) begin
                applied_q <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                applied_q <= 1'b0;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`endif

    assign pending_o   = |dirty_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign range_err_o = range_err_q;

    assign r_budget_o = active_budget_q[0];
    assign r_period_o = active_period_q[0];
    assign w_budget_o = active_budget_q[1];
    assign w_period_o = active_period_q[1];

endmodule
